iic_byte_seq: RTL and testbench

Byte-level transaction sequencer for the APB-to-I2C bridge. It accepts one byte command at a time from the APB register front-end and breaks it into the START, data, ACK and STOP bit operations needed by the I2C bit engine. It returns one response per command: read data, slave NACK, arbitration loss or error. It sits between the APB slave register file and the bit engine, and is the only block that drives the engine's request port.

---
 rtl/iic_pkg.sv | 36 +++
 rtl/iic_op_wdt.sv | 31 +++
 rtl/iic_byte_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_iic_byte_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the I2C byte sequencer: bit-engine operation codes,
// sequencer state encoding, timeout default and the latched command record.
package iic_pkg;

    // Bit-engine operation codes presented on bit_op
    localparam logic [1:0] IIC_START = 2'd0;
    localparam logic [1:0] IIC_STOP  = 2'd1;
    localparam logic [1:0] IIC_WRITE = 2'd2;
    localparam logic [1:0] IIC_READ  = 2'd3;

    // Byte sequencer FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    // Default per-operation timeout in clock cycles (0 disables the watchdog)
    localparam int unsigned IIC_TOUT_CYC_DEFAULT = 1023;

    // Command fields captured at acceptance and held for the whole byte
    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       nack;
        logic [7:0] wdata;
    } iic_cmd_t;

    // Counter width able to hold a reload value of tout-1
    function automatic int unsigned wdt_width(input int unsigned tout);
        return (tout < 2) ? 1 : $clog2(tout);
    endfunction

endpackage

// File: rtl/iic_op_wdt.sv
// Per-operation watchdog: a loadable down-counter that flags expiry once it
// has sat at zero while enabled. A load always wins over counting.
module iic_op_wdt
    import iic_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_reg;

    // Reload on a new operation, otherwise count down towards zero while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign expired = en && (cnt_reg == '0);

endmodule

// File: rtl/iic_byte_seq.sv
// Byte-level I2C transaction sequencer. Turns one byte command into the
// START / 8 data bits / ACK / STOP bit operations for the bit engine and
// returns a single response pulse with read data and status flags.
module iic_byte_seq
    import iic_pkg::*;
#(
    parameter int unsigned TOUT_CYC = IIC_TOUT_CYC_DEFAULT
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    // command port from the register front-end
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] cmd_wdata,
    // bit-engine request port
    output logic       bit_req,
    output logic [1:0] bit_op,
    output logic       bit_wdat,
    input  logic       bit_done,
    input  logic       bit_rdat,
    input  logic       bit_arblost,
    // response port
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_arblost,
    output logic       rsp_err,
    output logic       busy
);

    localparam int unsigned       WDT_W    = wdt_width(TOUT_CYC);
    localparam logic [WDT_W-1:0]  WDT_LOAD = WDT_W'(TOUT_CYC - 1);
    localparam logic              WDT_ON   = (TOUT_CYC != 0);

    logic [2:0] state_reg,    state_next;
    logic [2:0] cnt_reg,      cnt_next;
    iic_cmd_t   cmd_reg,      cmd_next;
    logic       bit_req_reg,  bit_req_next;
    logic [1:0] bit_op_reg,   bit_op_next;
    logic       bit_wdat_reg, bit_wdat_next;
    logic [7:0] rdata_reg,    rdata_next;
    logic       nack_reg,     nack_next;
    logic       arb_reg,      arb_next;
    logic       err_reg,      err_next;
    logic       busy_reg,     busy_next;

    logic       wdt_load;
    logic       wdt_expired;
    logic       done_ok;
    logic [2:0] cnt_dec;

    // Completions only count against an outstanding request
    assign done_ok = bit_done && bit_req_reg;
    assign cnt_dec = cnt_reg - 3'd1;

    iic_op_wdt #(
        .W (WDT_W)
    ) u_wdt (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (wdt_load),
        .load_val (WDT_LOAD),
        .en       (bit_req_reg && WDT_ON),
        .expired  (wdt_expired)
    );

    // Next-state logic: sequences the bit operations of one byte command
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cmd_next      = cmd_reg;
        bit_req_next  = bit_req_reg;
        bit_op_next   = bit_op_reg;
        bit_wdat_next = bit_wdat_reg;
        rdata_next    = rdata_reg;
        nack_next     = nack_reg;
        arb_next      = arb_reg;
        err_next      = err_reg;
        busy_next     = busy_reg;
        wdt_load      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_next.start = cmd_start;
                    cmd_next.stop  = cmd_stop;
                    cmd_next.read  = cmd_read;
                    cmd_next.nack  = cmd_nack;
                    cmd_next.wdata = cmd_wdata;
                    rdata_next     = 8'h00;
                    nack_next      = 1'b0;
                    arb_next       = 1'b0;
                    err_next       = 1'b0;
                    if (cmd_start) begin
                        state_next    = ST_START;
                        bit_req_next  = 1'b1;
                        bit_op_next   = IIC_START;
                        bit_wdat_next = 1'b0;
                        wdt_load      = 1'b1;
                    end else if (!busy_reg) begin
                        // data byte without owning the bus is a protocol error
                        state_next = ST_RESP;
                        err_next   = 1'b1;
                    end else begin
                        state_next    = ST_DATA;
                        cnt_next      = 3'd7;
                        bit_req_next  = 1'b1;
                        bit_op_next   = cmd_read ? IIC_READ : IIC_WRITE;
                        bit_wdat_next = cmd_read ? 1'b0 : cmd_wdata[7];
                        wdt_load      = 1'b1;
                    end
                end
            end

            ST_START: begin
                if (done_ok) begin
                    busy_next     = 1'b1;
                    state_next    = ST_DATA;
                    cnt_next      = 3'd7;
                    bit_op_next   = cmd_reg.read ? IIC_READ : IIC_WRITE;
                    bit_wdat_next = cmd_reg.read ? 1'b0 : cmd_reg.wdata[7];
                    wdt_load      = 1'b1;
                end
            end

            ST_DATA: begin
                if (done_ok) begin
                    if (cmd_reg.read) begin
                        rdata_next = {rdata_reg[6:0], bit_rdat};
                    end
                    wdt_load = 1'b1;
                    if (cnt_reg == 3'd0) begin
                        // acknowledge phase: master samples on write, drives on read
                        state_next    = ST_ACK;
                        bit_op_next   = cmd_reg.read ? IIC_WRITE : IIC_READ;
                        bit_wdat_next = cmd_reg.read ? cmd_reg.nack : 1'b0;
                    end else begin
                        cnt_next      = cnt_dec;
                        bit_wdat_next = cmd_reg.read ? 1'b0 : cmd_reg.wdata[cnt_dec];
                    end
                end
            end

            ST_ACK: begin
                if (done_ok) begin
                    if (!cmd_reg.read) begin
                        nack_next = bit_rdat;
                    end
                    if (cmd_reg.stop) begin
                        state_next    = ST_STOP;
                        bit_op_next   = IIC_STOP;
                        bit_wdat_next = 1'b0;
                        wdt_load      = 1'b1;
                    end else begin
                        state_next   = ST_RESP;
                        bit_req_next = 1'b0;
                    end
                end
            end

            ST_STOP: begin
                if (done_ok) begin
                    busy_next    = 1'b0;
                    state_next   = ST_RESP;
                    bit_req_next = 1'b0;
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next   = ST_IDLE;
                bit_req_next = 1'b0;
            end
        endcase

        // Losing arbitration abandons the bus at once; no STOP is attempted
        if (done_ok && bit_arblost) begin
            state_next   = ST_RESP;
            bit_req_next = 1'b0;
            busy_next    = 1'b0;
            arb_next     = 1'b1;
            wdt_load     = 1'b0;
        end else if (wdt_expired && !done_ok) begin
            // Engine stalled: withdraw the request and report an error
            state_next   = ST_RESP;
            bit_req_next = 1'b0;
            busy_next    = 1'b0;
            err_next     = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 3'd0;
            cmd_reg      <= '0;
            bit_req_reg  <= 1'b0;
            bit_op_reg   <= IIC_START;
            bit_wdat_reg <= 1'b0;
            rdata_reg    <= 8'h00;
            nack_reg     <= 1'b0;
            arb_reg      <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cmd_reg      <= cmd_next;
            bit_req_reg  <= bit_req_next;
            bit_op_reg   <= bit_op_next;
            bit_wdat_reg <= bit_wdat_next;
            rdata_reg    <= rdata_next;
            nack_reg     <= nack_next;
            arb_reg      <= arb_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
        end
    end

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign rsp_valid   = (state_reg == ST_RESP);
    assign bit_req     = bit_req_reg;
    assign bit_op      = bit_op_reg;
    assign bit_wdat    = bit_wdat_reg;
    assign rsp_rdata   = rdata_reg;
    assign rsp_nack    = nack_reg;
    assign rsp_arblost = arb_reg;
    assign rsp_err     = err_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_iic_byte_seq.sv
// Scoreboard bench for iic_byte_seq: stimulus pushes expected bit operations
// and responses into queues; monitor processes pop and compare them.
module tb_iic_byte_seq;
    import iic_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
    logic       cmd_read = 1'b0, cmd_nack = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       bit_req, bit_wdat;
    logic [1:0] bit_op;
    logic       bit_done = 1'b0, bit_rdat = 1'b0, bit_arblost = 1'b0;
    logic       rsp_valid, rsp_nack, rsp_arblost, rsp_err, busy;
    logic [7:0] rsp_rdata;

    always #5 PCLK = ~PCLK;

    iic_byte_seq #(.TOUT_CYC(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_nack(cmd_nack),
        .cmd_wdata(cmd_wdata),
        .bit_req(bit_req), .bit_op(bit_op), .bit_wdat(bit_wdat),
        .bit_done(bit_done), .bit_rdat(bit_rdat), .bit_arblost(bit_arblost),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .rsp_arblost(rsp_arblost), .rsp_err(rsp_err), .busy(busy)
    );

    typedef struct { logic [1:0] op; logic wdat; logic busy; } exp_op_t;
    typedef struct { logic rd; logic arb; } eng_t;
    typedef struct {
        logic [7:0] rdata; logic chk_rdata;
        logic nack; logic arb; logic err; logic busy; int lat;
    } exp_rsp_t;

    exp_op_t  op_q[$];
    eng_t     eng_q[$];
    exp_rsp_t rsp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int req_cnt = 0;
    bit eng_on = 1'b1;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_op(input logic [1:0] op, input logic wdat, input logic b);
        exp_op_t e;
        e.op = op; e.wdat = wdat; e.busy = b;
        op_q.push_back(e);
    endtask

    task automatic push_wbyte(input logic [7:0] v, input logic b);
        for (int i = 7; i >= 0; i--) push_op(IIC_WRITE, v[i], b);
    endtask

    task automatic push_eng(input logic rd, input logic arb);
        eng_t e;
        e.rd = rd; e.arb = arb;
        eng_q.push_back(e);
    endtask

    task automatic push_rbyte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) push_eng(v[i], 1'b0);
    endtask

    task automatic push_rsp(input logic [7:0] rdata, input logic chk_rd, input logic nack,
                            input logic arb, input logic err, input logic b, input int lat);
        exp_rsp_t r;
        r.rdata = rdata; r.chk_rdata = chk_rd; r.nack = nack;
        r.arb = arb; r.err = err; r.busy = b; r.lat = lat;
        rsp_q.push_back(r);
    endtask

    // Bit-engine model with op checker: zero-wait completion of every request
    always @(negedge PCLK) begin
        exp_op_t e;
        eng_t    g;
        if (PRESETn && bit_req && eng_on) begin
            if (op_q.size() == 0) begin
                chk("op_expected", 0, 1);
            end else begin
                e = op_q.pop_front();
                chk("bit_op", bit_op, e.op);
                chk("busy_during_op", busy, e.busy);
                if (e.op == IIC_WRITE) chk("bit_wdat", bit_wdat, e.wdat);
            end
            if (eng_q.size() > 0) g = eng_q.pop_front();
            else begin g.rd = 1'b0; g.arb = 1'b0; end
            bit_done = 1'b1; bit_rdat = g.rd; bit_arblost = g.arb;
        end else begin
            bit_done = 1'b0; bit_rdat = 1'b0; bit_arblost = 1'b0;
        end
        if (bit_req) req_cnt++;
    end

    // Response monitor
    always @(negedge PCLK) begin
        exp_rsp_t r;
        if (PRESETn && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_expected", 0, 1);
            end else begin
                r = rsp_q.pop_front();
                $display("rsp: rdata=%02h nack=%0b arb=%0b err=%0b busy=%0b lat=%0d",
                         rsp_rdata, rsp_nack, rsp_arblost, rsp_err, busy, cyc - acc_cyc + 1);
                chk("rsp_nack", rsp_nack, r.nack);
                chk("rsp_arblost", rsp_arblost, r.arb);
                chk("rsp_err", rsp_err, r.err);
                chk("busy_at_rsp", busy, r.busy);
                chk("rsp_latency", cyc - acc_cyc + 1, r.lat);
                if (r.chk_rdata) chk("rsp_rdata", rsp_rdata, r.rdata);
            end
        end
    end

    task automatic issue(input logic s, input logic p, input logic r, input logic n,
                         input logic [7:0] w);
        @(negedge PCLK);
        chk("cmd_ready", cmd_ready, 1);
        cmd_start = s; cmd_stop = p; cmd_read = r; cmd_nack = n; cmd_wdata = w;
        cmd_valid = 1'b1;
        @(posedge PCLK);
        #1;
        acc_cyc = cyc;
        req_cnt = 0;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (rsp_q.size() == 0) break;
        end
        chk("rsp_pending", rsp_q.size(), 0);
        chk("ops_pending", op_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_bit_req", bit_req, 0);
        chk("rst_bit_op", bit_op, 0);
        chk("rst_bit_wdat", bit_wdat, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_nack", rsp_nack, 0);
        chk("rst_rsp_arblost", rsp_arblost, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_reset_vals();
        PRESETn = 1'b1;

        // Write 0xA5 with START and STOP, slave ACKs
        push_op(IIC_START, 1'b0, 1'b0);
        push_wbyte(8'hA5, 1'b1);
        push_op(IIC_READ, 1'b0, 1'b1);
        push_op(IIC_STOP, 1'b0, 1'b1);
        push_rsp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        wait_rsp();

        // Address byte 0x50 with START, no STOP: bus stays owned
        push_op(IIC_START, 1'b0, 1'b0);
        push_wbyte(8'h50, 1'b1);
        push_op(IIC_READ, 1'b0, 1'b1);
        push_rsp(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h50);
        wait_rsp();

        // Read 0x3C while busy, master NACK, then STOP
        push_rbyte(8'h3C);
        for (int i = 0; i < 8; i++) push_op(IIC_READ, 1'b0, 1'b1);
        push_op(IIC_WRITE, 1'b1, 1'b1);
        push_op(IIC_STOP, 1'b0, 1'b1);
        push_rsp(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        wait_rsp();

        // Data byte without START while the bus is free: immediate error
        push_rsp(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'h33);
        wait_rsp();
        chk("no_req_on_err", req_cnt, 0);

        // Write 0x80, slave NACKs, STOP still issued
        push_eng(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_eng(1'b0, 1'b0);
        push_eng(1'b1, 1'b0);
        push_op(IIC_START, 1'b0, 1'b0);
        push_wbyte(8'h80, 1'b1);
        push_op(IIC_READ, 1'b0, 1'b1);
        push_op(IIC_STOP, 1'b0, 1'b1);
        push_rsp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h80);
        wait_rsp();

        // Arbitration lost on the fourth data bit
        push_eng(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_eng(1'b0, 1'b0);
        push_eng(1'b0, 1'b1);
        push_op(IIC_START, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_op(IIC_WRITE, 1'b1, 1'b1);
        push_rsp(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        wait_rsp();
        repeat (3) @(negedge PCLK);
        chk("no_op_after_arb", req_cnt, 5);

        // Engine never completes: timeout after 8 request cycles
        eng_on = 1'b0;
        push_rsp(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h12);
        wait_rsp();
        chk("tout_req_cycles", req_cnt, 8);

        // Read 0x96 with START, no STOP, leaves bus owned and data held
        eng_on = 1'b1;
        push_eng(1'b0, 1'b0);
        push_rbyte(8'h96);
        push_op(IIC_START, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_op(IIC_READ, 1'b0, 1'b1);
        push_op(IIC_WRITE, 1'b0, 1'b1);
        push_rsp(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        wait_rsp();

        // Reset in the middle of a stalled write
        eng_on = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        repeat (3) @(negedge PCLK);
        chk("mid_bit_req", bit_req, 1);
        chk("mid_bit_op", bit_op, IIC_WRITE);
        chk("mid_busy", busy, 1);
        PRESETn = 1'b0;
        #1;
        check_reset_vals();
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (4) @(negedge PCLK);
        chk("post_rst_bit_req", bit_req, 0);
        chk("stray_rsp", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
